// File: rtl/t03_pkg.sv
// t03_pkg: shared types and constants for the Wishbone manager
package t03_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam logic [DW-1:0] DEF_ERR_DATA = 32'hBAD0_BAD0;
endpackage

// File: rtl/t03_wb_timeout_counter.sv
// t03_wb_timeout_counter: saturating no-ack cycle counter with terminal count
module t03_wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = t03_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tc = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt <= '0;
    else cnt <= clr ? '0 : (en && !tc) ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/t03_wishbone_manager.sv
// t03_wishbone_manager: CPU request pulses to Wishbone B4 classic single-beat cycles
module t03_wishbone_manager
  import t03_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [DW-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          read_i,
  input  logic          write_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] cpu_dat_i,
  input  logic [3:0]    sel_i,
  output logic [DW-1:0] cpu_dat_o,
  output logic          busy_o,
  output logic          timeout_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic [3:0]    sel_o,
  output logic          we_o,
  output logic          cyc_o,
  output logic          stb_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);
  state_t state_q, state_d;
  logic accept, done, tc;
  always_comb begin
    accept = state_q == IDLE && (read_i || write_i);
    done = state_q == WAIT_ACK && (ack_i || tc);
    state_d = accept ? WAIT_ACK : done ? IDLE : state_q;
  end
  t03_wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk (clk),
    .nrst(nrst),
    .clr (state_q != WAIT_ACK || done),
    .en  (state_q == WAIT_ACK && !ack_i),
    .tc  (tc)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      cpu_dat_o <= '0;
      busy_o <= 1'b0;
      timeout_o <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      we_o <= 1'b0;
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_o <= adr_i;
        dat_o <= write_i ? cpu_dat_i : '0;
        sel_o <= sel_i;
        we_o <= write_i;
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        busy_o <= 1'b1;
        timeout_o <= 1'b0;
      end else if (done) begin
        // ack beats a coincident terminal count
        if (!we_o) cpu_dat_o <= ack_i ? dat_i : ERR_DATA;
        we_o <= 1'b0;
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        busy_o <= 1'b0;
        timeout_o <= !ack_i;
      end
    end
endmodule

// File: tb/tb_t03_wishbone_manager.sv
// tb_t03_wishbone_manager: directed tests of the Wishbone manager with TIMEOUT_CYCLES=4
module tb_t03_wishbone_manager;
  logic clk = 1'b0, nrst = 1'b0;
  logic read_i = 1'b0, write_i = 1'b0, ack_i = 1'b0;
  logic [31:0] adr_i = '0, cpu_dat_i = '0, dat_i = '0;
  logic [3:0] sel_i = '0;
  logic [31:0] cpu_dat_o, adr_o, dat_o;
  logic [3:0] sel_o;
  logic busy_o, timeout_o, we_o, cyc_o, stb_o;
  int checks = 0, errors = 0;

  t03_wishbone_manager #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hBAD0_BAD0)) dut (
    .clk(clk), .nrst(nrst), .read_i(read_i), .write_i(write_i), .adr_i(adr_i),
    .cpu_dat_i(cpu_dat_i), .sel_i(sel_i), .cpu_dat_o(cpu_dat_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++; if ({cpu_dat_o, busy_o, timeout_o, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o} !== '0) begin errors++; $display("FAIL reset_idle outs=%h want 0", {cpu_dat_o, busy_o, timeout_o, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o}); end
    nrst = 1'b1;
    step();
    checks++; if ({busy_o, cyc_o, stb_o} !== 3'b000) begin errors++; $display("FAIL reset_release busy/cyc/stb=%b want 000", {busy_o, cyc_o, stb_o}); end
  endtask

  task automatic test_read();
    read_i = 1'b1; adr_i = 32'h3300_0040; sel_i = 4'hF;
    step();
    read_i = 1'b0; adr_i = '0;
    checks++; if ({busy_o, cyc_o, stb_o, we_o} !== 4'b1110) begin errors++; $display("FAIL read_start busy/cyc/stb/we=%b want 1110", {busy_o, cyc_o, stb_o, we_o}); end
    checks++; if (adr_o !== 32'h3300_0040 || sel_o !== 4'hF || dat_o !== '0) begin errors++; $display("FAIL read_bus adr=%h sel=%h dat=%h want 33000040 f 0", adr_o, sel_o, dat_o); end
    step();
    step();
    checks++; if (adr_o !== 32'h3300_0040 || {busy_o, cyc_o, stb_o, we_o} !== 4'b1110) begin errors++; $display("FAIL read_hold adr=%h flags=%b want 33000040 1110", adr_o, {busy_o, cyc_o, stb_o, we_o}); end
    ack_i = 1'b1; dat_i = 32'h1234_5678;
    step();
    ack_i = 1'b0; dat_i = '0;
    checks++; if ({busy_o, cyc_o, stb_o} !== 3'b000) begin errors++; $display("FAIL read_done busy/cyc/stb=%b want 000", {busy_o, cyc_o, stb_o}); end
    checks++; if (cpu_dat_o !== 32'h1234_5678 || timeout_o !== 1'b0) begin errors++; $display("FAIL read_data cpu_dat=%h to=%b want 12345678 0", cpu_dat_o, timeout_o); end
  endtask

  task automatic test_write();
    write_i = 1'b1; adr_i = 32'h3300_0100; cpu_dat_i = 32'hCAFE_F00D; sel_i = 4'h3;
    step();
    write_i = 1'b0;
    checks++; if ({busy_o, cyc_o, stb_o, we_o} !== 4'b1111) begin errors++; $display("FAIL write_start flags=%b want 1111", {busy_o, cyc_o, stb_o, we_o}); end
    checks++; if (adr_o !== 32'h3300_0100 || dat_o !== 32'hCAFE_F00D || sel_o !== 4'h3) begin errors++; $display("FAIL write_bus adr=%h dat=%h sel=%h want 33000100 cafef00d 3", adr_o, dat_o, sel_o); end
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    checks++; if ({busy_o, cyc_o, stb_o, we_o} !== 4'b0000) begin errors++; $display("FAIL write_done flags=%b want 0000", {busy_o, cyc_o, stb_o, we_o}); end
    checks++; if (cpu_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL write_cpu_dat got=%h want 12345678", cpu_dat_o); end
  endtask

  task automatic test_ignored();
    read_i = 1'b1; write_i = 1'b1; adr_i = 32'h3300_0200; cpu_dat_i = 32'h1111_2222; sel_i = 4'hF;
    step();
    write_i = 1'b0; adr_i = 32'h3300_0300;
    checks++; if (we_o !== 1'b1 || dat_o !== 32'h1111_2222 || adr_o !== 32'h3300_0200) begin errors++; $display("FAIL both_req we=%b dat=%h adr=%h want 1 11112222 33000200", we_o, dat_o, adr_o); end
    step();
    read_i = 1'b0;
    checks++; if (adr_o !== 32'h3300_0200 || we_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL busy_read_ignored adr=%h we=%b busy=%b want 33000200 1 1", adr_o, we_o, busy_o); end
    ack_i = 1'b1;
    step();
    checks++; if ({busy_o, cyc_o} !== 2'b00) begin errors++; $display("FAIL both_done busy/cyc=%b want 00", {busy_o, cyc_o}); end
    step();
    ack_i = 1'b0;
    checks++; if ({busy_o, cyc_o, stb_o, timeout_o} !== 4'b0000 || cpu_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL idle_ack flags=%b cpu_dat=%h want 0000 12345678", {busy_o, cyc_o, stb_o, timeout_o}, cpu_dat_o); end
  endtask

  task automatic test_timeout();
    read_i = 1'b1; adr_i = 32'h3300_0400; sel_i = 4'h1;
    step();
    read_i = 1'b0;
    step(); step(); step();
    checks++; if ({busy_o, cyc_o} !== 2'b11) begin errors++; $display("FAIL timeout_wait4 busy/cyc=%b want 11", {busy_o, cyc_o}); end
    step();
    checks++; if ({busy_o, cyc_o, stb_o} !== 3'b000 || timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_abort flags=%b to=%b want 000 1", {busy_o, cyc_o, stb_o}, timeout_o); end
    checks++; if (cpu_dat_o !== 32'hBAD0_BAD0) begin errors++; $display("FAIL timeout_data got=%h want bad0bad0", cpu_dat_o); end
    step();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b want 1", timeout_o); end
  endtask

  task automatic test_ack_vs_timeout();
    read_i = 1'b1; adr_i = 32'h3300_0500;
    step();
    read_i = 1'b0;
    checks++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL timeout_clear to=%b busy=%b want 0 1", timeout_o, busy_o); end
    step(); step(); step();
    ack_i = 1'b1; dat_i = 32'h0000_00AA;
    step();
    ack_i = 1'b0; dat_i = '0;
    checks++; if (cpu_dat_o !== 32'h0000_00AA || timeout_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL ack_at_tc cpu_dat=%h to=%b busy=%b want aa 0 0", cpu_dat_o, timeout_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    read_i = 1'b1; adr_i = 32'h3300_0600;
    step();
    read_i = 1'b0; ack_i = 1'b1; dat_i = 32'h0000_0001;
    step();
    ack_i = 1'b0; read_i = 1'b1; adr_i = 32'h3300_0604;
    step();
    read_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || adr_o !== 32'h3300_0604 || cpu_dat_o !== 32'h0000_0001) begin errors++; $display("FAIL back_to_back busy=%b adr=%h cpu_dat=%h want 1 33000604 1", busy_o, adr_o, cpu_dat_o); end
  endtask

  task automatic test_async_reset();
    checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL pre_reset cyc=%b want 1", cyc_o); end
    #2 nrst = 1'b0;
    #1;
    checks++; if ({cyc_o, stb_o, busy_o} !== 3'b000) begin errors++; $display("FAIL async_drop cyc/stb/busy=%b want 000", {cyc_o, stb_o, busy_o}); end
    step();
    #2 nrst = 1'b1;
    step();
    checks++; if ({cpu_dat_o, busy_o, timeout_o, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o} !== '0) begin errors++; $display("FAIL post_reset outs=%h want 0", {cpu_dat_o, busy_o, timeout_o, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o}); end
  endtask

  initial begin
    #1;
    test_reset();
    test_read();
    test_write();
    test_ignored();
    test_timeout();
    test_ack_vs_timeout();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
